// File: rtl/cvxif_sched_pkg.sv
// cvxif_sched_pkg
// Shared types for the CV-X-IF issue scheduler:
//   - entry_state_e : lifecycle of a buffered offload (waiting, committed, killed)
//   - fifo_entry_t  : one buffered offload with payload, lifecycle state and valid bit
//   - sched_state_e : dispatch/result FSM states
// The Sched* widths fix the entry layout; the top-level parameters default to them and
// must be kept equal when overridden.
package cvxif_sched_pkg;

    localparam int unsigned SchedXlen        = 32;
    localparam int unsigned SchedNrRgprPorts = 2;
    localparam int unsigned SchedHartIdWidth = 1;
    localparam int unsigned SchedIdWidth     = 3;
    localparam int unsigned OpcodeWidth      = 4;
    localparam int unsigned RegAddrWidth     = 5;

    typedef enum logic [1:0] {
        EntryWaitCommit = 2'd0,
        EntryCommitted  = 2'd1,
        EntryKilled     = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic [OpcodeWidth-1:0]                  opcode;
        logic [SchedHartIdWidth-1:0]             hartid;
        logic [SchedIdWidth-1:0]                 id;
        logic [RegAddrWidth-1:0]                 rd;
        logic                                    we;
        logic [SchedNrRgprPorts*SchedXlen-1:0]   registers;
        entry_state_e                            state;
        logic                                    valid;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBusy   = 2'd1,
        StResult = 2'd2
    } sched_state_e;

    // Lifecycle state an entry takes when its commit message arrives.
    function automatic entry_state_e resolve_state(input logic kill);
        return kill ? EntryKilled : EntryCommitted;
    endfunction

endpackage

// File: rtl/cvxif_sched_buffer.sv
// cvxif_sched_buffer
// In-order circular buffer of offloaded instructions awaiting commit/kill.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_valid/ready   enqueue handshake; push_entry carries the payload (state/valid ignored)
//   commit_valid/id/kill  commit message, matched by id against waiting entries
//   pop_dispatch       head was accepted by the execution unit
//   head               current head entry (valid=0 when empty)
//   count              number of occupied entries
// Killed head entries are popped here without involving the dispatcher.
module cvxif_sched_buffer
    import cvxif_sched_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrWidth = $clog2(Depth),
    localparam int unsigned CntWidth = $clog2(Depth) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  fifo_entry_t             push_entry,
    input  logic                    commit_valid,
    input  logic [SchedIdWidth-1:0] commit_id,
    input  logic                    commit_kill,
    input  logic                    pop_dispatch,
    output fifo_entry_t             head,
    output logic [CntWidth-1:0]     count
);

    fifo_entry_t         mem_q [Depth];
    fifo_entry_t         mem_d [Depth];
    logic [PtrWidth-1:0] head_q, head_d;
    logic [PtrWidth-1:0] tail_q, tail_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                push;
    logic                pop;
    logic                head_killed;

    // Registered count only, so a pop in the same cycle cannot make room for a push.
    assign push_ready  = count_q < CntWidth'(Depth);
    assign push        = push_valid && push_ready;
    assign head        = mem_q[head_q];
    assign head_killed = head.valid && (head.state == EntryKilled);
    assign pop         = head_killed || pop_dispatch;
    assign count       = count_q;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CntWidth'(push) - CntWidth'(pop);

        for (int i = 0; i < Depth; i++) begin
            if (commit_valid && mem_q[i].valid && (mem_q[i].state == EntryWaitCommit)
                && (mem_q[i].id == commit_id)) begin
                mem_d[i].state = resolve_state(commit_kill);
            end
        end

        if (pop) begin
            mem_d[head_q] = '0;
            head_d        = head_q + PtrWidth'(1);
        end

        if (push) begin
            mem_d[tail_q]       = push_entry;
            mem_d[tail_q].valid = 1'b1;
            // A commit arriving with the offload itself applies to the new entry.
            if (commit_valid && (commit_id == push_entry.id)) begin
                mem_d[tail_q].state = resolve_state(commit_kill);
            end else begin
                mem_d[tail_q].state = EntryWaitCommit;
            end
            tail_d = tail_q + PtrWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cvxif_issue_scheduler.sv
// cvxif_issue_scheduler
// Sequences CV-X-IF offloads onto one shared coprocessor execution unit.
// Ports:
//   in_*       accepted offloads from the decoder (valid/ready)
//   commit_*   commit or kill messages from the core, matched by id
//   exe_*      dispatch request (valid/ready) and completion (done/data) of the unit
//   result_*   CV-X-IF result interface with backpressure
//   count_o    occupied buffer entries
// The buffer holds offloads in order; this level runs the IDLE/BUSY/RESULT FSM that
// dispatches the committed head, waits for completion and returns the result.
module cvxif_issue_scheduler
    import cvxif_sched_pkg::*;
#(
    parameter int unsigned Depth       = 4,
    parameter int unsigned XLEN        = SchedXlen,
    parameter int unsigned NrRgprPorts = SchedNrRgprPorts,
    parameter int unsigned HartIdWidth = SchedHartIdWidth,
    parameter int unsigned IdWidth     = SchedIdWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [3:0]                    in_opcode_i,
    input  logic [HartIdWidth-1:0]        in_hartid_i,
    input  logic [IdWidth-1:0]            in_id_i,
    input  logic [4:0]                    in_rd_i,
    input  logic                          in_we_i,
    input  logic [NrRgprPorts*XLEN-1:0]   in_registers_i,
    input  logic                          commit_valid_i,
    input  logic [IdWidth-1:0]            commit_id_i,
    input  logic                          commit_kill_i,
    output logic                          exe_valid_o,
    input  logic                          exe_ready_i,
    output logic [3:0]                    exe_opcode_o,
    output logic [NrRgprPorts*XLEN-1:0]   exe_registers_o,
    input  logic                          exe_done_i,
    input  logic [XLEN-1:0]               exe_data_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [IdWidth-1:0]            result_id_o,
    output logic [HartIdWidth-1:0]        result_hartid_o,
    output logic [4:0]                    result_rd_o,
    output logic                          result_we_o,
    output logic [XLEN-1:0]               result_data_o,
    output logic [$clog2(Depth):0]        count_o
);

    fifo_entry_t      in_entry;
    fifo_entry_t      head;
    logic             head_committed;
    logic             dispatch;

    sched_state_e     state_q, state_d;
    logic [IdWidth-1:0]     res_id_q, res_id_d;
    logic [HartIdWidth-1:0] res_hartid_q, res_hartid_d;
    logic [4:0]             res_rd_q, res_rd_d;
    logic                   res_we_q, res_we_d;
    logic [XLEN-1:0]        res_data_q, res_data_d;

    always_comb begin
        in_entry           = '0;
        in_entry.opcode    = in_opcode_i;
        in_entry.hartid    = in_hartid_i;
        in_entry.id        = in_id_i;
        in_entry.rd        = in_rd_i;
        in_entry.we        = in_we_i;
        in_entry.registers = in_registers_i;
    end

    cvxif_sched_buffer #(
        .Depth (Depth)
    ) u_buffer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_valid   (in_valid_i),
        .push_ready   (in_ready_o),
        .push_entry   (in_entry),
        .commit_valid (commit_valid_i),
        .commit_id    (commit_id_i),
        .commit_kill  (commit_kill_i),
        .pop_dispatch (dispatch),
        .head         (head),
        .count        (count_o)
    );

    assign head_committed  = head.valid && (head.state == EntryCommitted);
    // Payload follows the head directly; it is stable while the head waits for acceptance.
    assign exe_opcode_o    = head.opcode;
    assign exe_registers_o = head.registers;

    always_comb begin
        state_d        = state_q;
        res_id_d       = res_id_q;
        res_hartid_d   = res_hartid_q;
        res_rd_d       = res_rd_q;
        res_we_d       = res_we_q;
        res_data_d     = res_data_q;
        exe_valid_o    = 1'b0;
        result_valid_o = 1'b0;
        dispatch       = 1'b0;

        unique case (state_q)
            StIdle: begin
                exe_valid_o = head_committed;
                if (head_committed && exe_ready_i) begin
                    dispatch     = 1'b1;
                    res_id_d     = head.id;
                    res_hartid_d = head.hartid;
                    res_rd_d     = head.rd;
                    res_we_d     = head.we;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                if (exe_done_i) begin
                    res_data_d = exe_data_i;
                    state_d    = StResult;
                end
            end
            StResult: begin
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            res_id_q     <= '0;
            res_hartid_q <= '0;
            res_rd_q     <= '0;
            res_we_q     <= 1'b0;
            res_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            res_id_q     <= res_id_d;
            res_hartid_q <= res_hartid_d;
            res_rd_q     <= res_rd_d;
            res_we_q     <= res_we_d;
            res_data_q   <= res_data_d;
        end
    end

    assign result_id_o     = res_id_q;
    assign result_hartid_o = res_hartid_q;
    assign result_rd_o     = res_rd_q;
    assign result_we_o     = res_we_q;
    assign result_data_o   = res_data_q;

endmodule
